// File: rtl/crypto_stream_ctrl.sv
// Flow-controlled feeder for the combinational crypto coproc: input FIFO, one-hot
// enc/dec drive held for SETTLE cycles, single-entry result register on a valid/ready stream.
module crypto_stream_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_mode,
  output logic [DATA_W-1:0]        cp_data_in,
  output logic                     cp_enc,
  output logic                     cp_dec,
  input  logic [DATA_W-1:0]        cp_data_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  // state | meaning
  // IDLE  | nothing at the coproc; pop when the FIFO holds a word
  // WAIT  | operand and enc/dec driven, counting down the settle time
  // HOLD  | result presented on out_*, waiting for the consumer
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(SETTLE + 1);

  state_t state, state_d;

  logic [DATA_W:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [TW-1:0]     cnt;
  logic [DATA_W:0]   head;
  logic              push, pop, capture, mode_q;

  // Acceptance depends on occupancy only, so a full FIFO refuses even during a pop.
  assign in_ready = fifo_count < CW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == TW'(1)) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (fifo_count != '0) begin
            pop     = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_mode, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_data_in <= '0;
      cp_enc     <= 1'b0;
      cp_dec     <= 1'b0;
      mode_q     <= 1'b0;
      cnt        <= '0;
      out_data   <= '0;
      out_mode   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (state == HOLD && out_ready) out_valid <= 1'b0;
      if (pop) begin
        cp_data_in <= head[DATA_W-1:0];
        cp_enc     <= ~head[DATA_W];
        cp_dec     <= head[DATA_W];
        mode_q     <= head[DATA_W];
        cnt        <= TW'(SETTLE);
      end
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (capture) begin
          out_data  <= cp_data_out;
          out_mode  <= mode_q;
          out_valid <= 1'b1;
          cp_enc    <= 1'b0;
          cp_dec    <= 1'b0;
        end
      end
    end
  end

endmodule
